tmp_dig_seq: RTL

//  Parametrised successor of the temperature-sensor phase sequencer. It drives the precharge, diode,
//  big-diode and H/L-charge switch phases of the SC front-end, and chops src_n/snk from the comparator.
//  It multiplexes NCH sensing diodes round-robin. Each conversion gives a CW-bit code with a valid/ready handshake.
//  It sits between the analog front-end switch bank and the readout/register interface.

---
 rtl/tmp_dig_seq.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tmp_dig_seq.sv
// Temperature-sensor phase sequencer: drives the SC front-end switch phases,
// chops the bias source/sink from the comparator, round-robins the sensing
// diodes and returns one code per conversion over a valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | all phases off, waiting for en
// S_PRE     | precharge with bias setup enabled, T_PRE cycles
// S_DIODE   | small diode (PII2) on, comparator clocks toggling, T_DIODE cycles
// S_BIG     | big diode (PI2) on: T_BIG settle cycles, then evaluation
// S_HCHG    | one-cycle high charge (PA/PB), sets H
// S_LCHG    | one-cycle low charge (PA/PC), sets L
// S_OUT     | one-cycle result capture, all charge switches on
// S_HOLD    | code presented with valid, waiting for ready
module tmp_dig_seq #(
    parameter int NCH      = 4,
    parameter int CW       = 8,
    parameter int T_PRE    = 11,
    parameter int T_DIODE  = 2,
    parameter int T_BIG    = 3,
    parameter int SETUP_N  = 6,
    parameter int MAX_EVAL = 255,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           cmp,
    input  logic           ready,
    output logic           PI1,
    output logic           PI2,
    output logic           PII1,
    output logic           PII2,
    output logic           PA,
    output logic           PB,
    output logic           PC,
    output logic           PD,
    output logic           src_n,
    output logic           snk,
    output logic           cmp_p1,
    output logic           cmp_p2,
    output logic           pre_chrg,
    output logic           setup_bias,
    output logic [CHW-1:0] ch_sel,
    output logic           valid,
    output logic [CW-1:0]  code,
    output logic [CHW-1:0] code_ch,
    output logic           timeout
);

    localparam int TMAX = (T_PRE > T_DIODE) ? ((T_PRE > T_BIG) ? T_PRE : T_BIG)
                                             : ((T_DIODE > T_BIG) ? T_DIODE : T_BIG);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SW   = $clog2(SETUP_N + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DIODE, S_BIG, S_HCHG, S_LCHG, S_OUT, S_HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           settle_q, settle_d;
    logic [SW-1:0]  setup_cnt_q, setup_cnt_d;
    logic           setup_done_q, setup_done_d;
    logic [CW-1:0]  eval_cnt_q, eval_cnt_d, eval_inc;
    logic           h_q, h_d, l_q, l_d;
    logic           to_flag_q, to_flag_d;
    logic [CHW-1:0] ch_sel_q, ch_sel_d;
    logic           chop;

    logic           pi2_q, pi2_d, pii2_q, pii2_d;
    logic           pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d;
    logic           src_n_q, src_n_d, snk_q, snk_d;
    logic           cmp_p1_q, cmp_p1_d, cmp_p2_q, cmp_p2_d;
    logic           pre_chrg_q, pre_chrg_d, setup_bias_q, setup_bias_d;
    logic           valid_q, valid_d, timeout_q, timeout_d;
    logic [CW-1:0]  code_q, code_d;
    logic [CHW-1:0] code_ch_q, code_ch_d;

    // Next state, counters and registered-output values, decoded from the next state
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        settle_d     = settle_q;
        setup_cnt_d  = setup_cnt_q;
        setup_done_d = setup_done_q;
        eval_cnt_d   = eval_cnt_q;
        h_d          = h_q;
        l_d          = l_q;
        to_flag_d    = to_flag_q;
        ch_sel_d     = ch_sel_q;
        valid_d      = valid_q;
        code_d       = code_q;
        code_ch_d    = code_ch_q;
        timeout_d    = timeout_q;
        src_n_d      = src_n_q;
        snk_d        = snk_q;
        chop         = 1'b0;
        eval_inc     = (eval_cnt_q == '1) ? eval_cnt_q : eval_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_PRE;
                    tmr_d   = TW'(T_PRE - 1);
                end
            end
            S_PRE: begin
                if (tmr_q == '0) begin
                    state_d = S_DIODE;
                    tmr_d   = TW'(T_DIODE - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_DIODE: begin
                if (tmr_q == '0) begin
                    state_d  = S_BIG;
                    tmr_d    = TW'(T_BIG - 1);
                    settle_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_BIG: begin
                if (settle_q) begin
                    chop = 1'b1;
                    if (!setup_done_q && !cmp) begin
                        setup_cnt_d = setup_cnt_q + 1'b1;
                        if (setup_cnt_q == SW'(SETUP_N - 1))
                            setup_done_d = 1'b1;
                    end
                    if (tmr_q == '0) begin
                        settle_d = 1'b0;
                        // bias not yet trimmed: loop back for another diode visit
                        if (!setup_done_d) begin
                            state_d = S_DIODE;
                            tmr_d   = TW'(T_DIODE - 1);
                        end
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end else begin
                    eval_cnt_d = eval_inc;
                    if (eval_inc == CW'(MAX_EVAL)) begin
                        state_d   = S_OUT;
                        to_flag_d = 1'b1;
                    end else if (cmp && !h_q) begin
                        state_d = S_HCHG;
                    end else if (!cmp && !l_q) begin
                        state_d = S_LCHG;
                    end else begin
                        chop = 1'b1;
                    end
                end
            end
            S_HCHG: begin
                h_d     = 1'b1;
                state_d = l_q ? S_OUT : S_BIG;
            end
            S_LCHG: begin
                l_d     = 1'b1;
                state_d = h_q ? S_OUT : S_BIG;
            end
            S_OUT: begin
                code_d     = eval_cnt_q;
                code_ch_d  = ch_sel_q;
                timeout_d  = to_flag_q;
                valid_d    = 1'b1;
                h_d        = 1'b0;
                l_d        = 1'b0;
                eval_cnt_d = '0;
                to_flag_d  = 1'b0;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (ready) begin
                    valid_d  = 1'b0;
                    ch_sel_d = (ch_sel_q == CHW'(NCH - 1)) ? '0 : ch_sel_q + 1'b1;
                    if (en) begin
                        state_d = S_DIODE;
                        tmr_d   = TW'(T_DIODE - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (chop) begin
            if (cmp) src_n_d = ~src_n_q;
            else     snk_d   = ~snk_q;
        end

        pre_chrg_d   = (state_d == S_PRE);
        pii2_d       = (state_d == S_DIODE);
        pi2_d        = (state_d == S_BIG);
        pa_d         = (state_d == S_HCHG) || (state_d == S_LCHG) || (state_d == S_OUT);
        pb_d         = (state_d == S_PRE) || (state_d == S_HCHG) || (state_d == S_OUT);
        pc_d         = (state_d == S_PRE) || (state_d == S_LCHG) || (state_d == S_OUT);
        pd_d         = (state_d == S_PRE) || (state_d == S_OUT);
        setup_bias_d = (state_d == S_PRE) || ((state_d != S_IDLE) && !setup_done_d);
        cmp_p1_d     = (state_d == S_DIODE) ? ~cmp_p1_q : cmp_p1_q;
        if (state_d == S_IDLE) begin
            cmp_p1_d = 1'b0;
            src_n_d  = 1'b0;
            snk_d    = 1'b0;
        end
        cmp_p2_d     = ~cmp_p1_d;
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            settle_q     <= 1'b0;
            setup_cnt_q  <= '0;
            setup_done_q <= 1'b0;
            eval_cnt_q   <= '0;
            h_q          <= 1'b0;
            l_q          <= 1'b0;
            to_flag_q    <= 1'b0;
            ch_sel_q     <= '0;
            pi2_q        <= 1'b0;
            pii2_q       <= 1'b0;
            pa_q         <= 1'b0;
            pb_q         <= 1'b0;
            pc_q         <= 1'b0;
            pd_q         <= 1'b0;
            src_n_q      <= 1'b0;
            snk_q        <= 1'b0;
            cmp_p1_q     <= 1'b0;
            cmp_p2_q     <= 1'b1;
            pre_chrg_q   <= 1'b0;
            setup_bias_q <= 1'b0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            code_q       <= '0;
            code_ch_q    <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            settle_q     <= settle_d;
            setup_cnt_q  <= setup_cnt_d;
            setup_done_q <= setup_done_d;
            eval_cnt_q   <= eval_cnt_d;
            h_q          <= h_d;
            l_q          <= l_d;
            to_flag_q    <= to_flag_d;
            ch_sel_q     <= ch_sel_d;
            pi2_q        <= pi2_d;
            pii2_q       <= pii2_d;
            pa_q         <= pa_d;
            pb_q         <= pb_d;
            pc_q         <= pc_d;
            pd_q         <= pd_d;
            src_n_q      <= src_n_d;
            snk_q        <= snk_d;
            cmp_p1_q     <= cmp_p1_d;
            cmp_p2_q     <= cmp_p2_d;
            pre_chrg_q   <= pre_chrg_d;
            setup_bias_q <= setup_bias_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            code_q       <= code_d;
            code_ch_q    <= code_ch_d;
        end
    end

    assign PI1        = 1'b0;
    assign PII1       = 1'b0;
    assign PI2        = pi2_q;
    assign PII2       = pii2_q;
    assign PA         = pa_q;
    assign PB         = pb_q;
    assign PC         = pc_q;
    assign PD         = pd_q;
    assign src_n      = src_n_q;
    assign snk        = snk_q;
    assign cmp_p1     = cmp_p1_q;
    assign cmp_p2     = cmp_p2_q;
    assign pre_chrg   = pre_chrg_q;
    assign setup_bias = setup_bias_q;
    assign ch_sel     = ch_sel_q;
    assign valid      = valid_q;
    assign code       = code_q;
    assign code_ch    = code_ch_q;
    assign timeout    = timeout_q;

endmodule
